mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 datapath multiplexer among four requesters. It registers a one-hot grant and drives the multiplexer's 2-bit select from the winning requester index. It sits directly in front of a 4-input mux whose select port it owns. When compiled with grant locking, it holds a grant for a bounded burst of cycles.

---
 rtl/mux4_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 4:1 datapath mux and registers a one-hot grant.
// Define MUX4_ARB_LOCK_EN to let an owner hold the grant for up to MAX_HOLD consecutive cycles.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic [1:0] select_o,
  output logic       valid_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 8 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_param
      $error("mux4_rr_arbiter: MAX_HOLD must be 1..8 and fit in CNT_W bits");
    end
  endgenerate

  state_t     state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic       found;
  logic       release_now;
  logic       take;

  // The mux select is the owner register itself, so it holds its last value in IDLE.
  assign select_o = owner;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req_i[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
        found  = 1'b1;
      end
    end
  end

`ifdef MUX4_ARB_LOCK_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign release_now = !req_i[owner] || (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt <= '0;
    end else if (take) begin
      hold_cnt <= '0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign release_now = 1'b1;
`endif

  // A new winner is taken from IDLE, or at the same edge a GRANT is released (no bubble).
  assign take = found && (state == IDLE || release_now);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= 2'd0;
      ptr     <= 2'd0;
      grant_o <= 4'b0000;
      valid_o <= 1'b0;
    end else if (take) begin
      state   <= GRANT;
      owner   <= winner;
      ptr     <= winner + 2'd1;
      grant_o <= 4'b0001 << winner;
      valid_o <= 1'b1;
    end else if (state == GRANT && release_now) begin
      state   <= IDLE;
      grant_o <= 4'b0000;
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter; expectations follow MUX4_ARB_LOCK_EN.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t vecs[13];

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .grant_o (grant),
    .select_o(sel),
    .valid_o (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] s,
                           input logic v);
    check({name, "_grant"}, grant, g);
    check({name, "_select"}, {2'b00, sel}, {2'b00, s});
    check({name, "_valid"}, {3'b000, valid}, {3'b000, v});
  endtask

  // Apply a request, let one rising edge sample it, then look 1 ns later.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_owner;
    logic [3:0] held;

    vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[6]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[8]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[9]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
    vecs[10] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[11] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 2'd1, 1'b0};

    rst = 1'b1;
    req = 4'b0000;
    #12;
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester, idle hold of select, and fairness on release.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].req);
      check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid);
    end

    // Full contention from a clean pointer.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(4'b1111);
`ifdef MUX4_ARB_LOCK_EN
      exp_owner = 2'((i / 4) % 4);
`else
      exp_owner = 2'(i % 4);
`endif
      check_out($sformatf("contend%0d", i), 4'b0001 << exp_owner, exp_owner, 1'b1);
    end

    // Outputs must not react to req between edges.
    held = grant;
    req = 4'b0000;
    #2;
    check("no_comb_path", grant, held);
    req = 4'b1111;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-grant, then first grant after deassertion.
    #1;
    rst = 1'b1;
    #1;
    check_out("async_rst", 4'b0000, 2'd0, 1'b0);
    req = 4'b0010;
    @(posedge clk);
    #1;
    check_out("rst_held", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0010);
    check_out("post_rst", 4'b0010, 2'd1, 1'b1);

    // Sole requester keeps the grant through hold expiry.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b0001);
      check_out($sformatf("sole%0d", i), 4'b0001, 2'd0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
